pin_capture: RTL and testbench
==============================

Name: pin_capture

Overview:
- Input-direction counterpart to the buffered pin drivers: takes D_IN_0 values from the top-level SB_IO tristate pins (MOSI/AUX/…).
- Synchronises each pin, glitch-filters it, detects edges, and logs every filtered level change with a timestamp into a small FIFO.
- Sits between the SB_IO input wires and the Bus Pirate protocol/logic-analyzer cores.

Parameters:
- WIDTH, 2, number of pins captured (bit 0 = AUX, bit 1 = MOSI).
- FILT_CYCLES, 3, consecutive synced cycles a new level must persist before acceptance (≥1).
- TS_W, 16, timestamp counter width.
- DEPTH, 8, event FIFO entries (power of two, ≥2).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset. Reset is asynchronous and active-low.
- enable, input, 1, capture enable; gates timestamping and event logging.
- din, input, WIDTH, raw pin values from SB_IO D_IN_0.
- level, output, WIDTH, filtered pin levels.
- rise, output, WIDTH, one-cycle pulse per bit on filtered 0→1.
- fall, output, WIDTH, one-cycle pulse per bit on filtered 1→0.
- evt_valid, output, 1, FIFO not empty.
- evt_ready, input, 1, consumer accepts head entry.
- evt_data, output, TS_W+WIDTH, head entry {timestamp, level}.
- overflow, output, 1, sticky: an event was dropped.
- clr_overflow, input, 1, clears overflow.

Behaviour:
- Reset values:
  - sync flops, level, rise, fall, filter counters, timestamp, FIFO pointers/count: 0.
  - evt_valid = 0, overflow = 0.
  - evt_data = 0 while empty after reset.
- Synchroniser: two flops per bit (s1 ← din, s2 ← s1), no reset bypass.
- Filter, per bit, with counter cnt of width clog2(FILT_CYCLES)+1:
  - If s2 == level: cnt ← 0.
  - Else if cnt == FILT_CYCLES−1: level ← s2, cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any return of s2 to level before acceptance restarts the count (glitch rejected).
- Latency: a din change first captured at edge E0 appears on level at edge E0+1+FILT_CYCLES. For FILT_CYCLES=3 that is 5 edges.
- Edge pulses:
  - rise/fall are registered and asserted the cycle after level changes, for exactly one cycle.
  - They are independent of enable.
- Timestamp:
  - Free-running up-counter while enable=1; wraps 2^TS_W−1 → 0 silently.
  - Held at 0 while enable=0.
- Event push:
  - Occurs on any edge where at least one level bit changes and enable=1.
  - Entry = {timestamp value before that edge, new level vector}.
  - Simultaneous changes on several bits produce one entry.
- FIFO:
  - Standard first-word-fall-through; evt_valid = (count≠0); evt_data = head entry.
  - Pop when evt_valid & evt_ready.
  - Push while full without a pop: the entry is dropped, FIFO unchanged, overflow ← 1.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only; the pop is impossible because valid=0.
  - Pointers wrap modulo DEPTH.
- overflow:
  - Set wins over clr_overflow in the same cycle.
  - Otherwise clr_overflow clears it.
- enable deassert: FIFO contents retained and still drainable; no new pushes.
- rst_n assertion mid-operation: all state cleared immediately. Pending FIFO entries are lost.

Decomposition:
- Shared package bp_pin_pkg:
  - pin index constants AUX=0, MOSI=1, MISO=2, CLOCK=3;
  - event field offsets (EVT_LVL_LSB=0, EVT_TS_LSB=WIDTH);
  - default TS_W and DEPTH.
- One natural sub-module, pin_filter: synchroniser + counter filter + edge pulse for a single bit, instantiated WIDTH times.
- The FIFO stays inline.

Test Plan:
- Reset: hold rst_n=0 with din=2'b11 → level=0, evt_valid=0, overflow=0. Release and keep din=2'b11, enable=1 → level=2'b11 five edges after first capture, one rise pulse per bit, one event {ts, 2'b11}.
- Glitch: din[1] high for 2 cycles then low, FILT_CYCLES=3 → level[1] stays 0, no rise, no event. Then high for 3 cycles → level[1]=1 at E0+4, event logged.
- Timestamp: enable=1, toggle din[0] at cycles 10 and 30 (relative to enable) with evt_ready=0 → two entries whose timestamps differ by exactly 20. Pop order equals push order.
- Overflow: evt_ready=0, generate 9 accepted changes with DEPTH=8 → 8 entries kept, 9th dropped, overflow=1. clr_overflow pulse → overflow=0, entries intact.
- Full boundary: FIFO full, evt_ready=1 on the same cycle as a new change → head popped, new entry appended, count stays 8, overflow stays 0.
- Enable/wrap: TS_W=4, enable=1 for 20 cycles → timestamp wraps 15→0. Drop enable → timestamp=0, changes update level/rise/fall but push no events.

Source files
------------

// File: rtl/bp_pin_pkg.sv
// Shared definitions for the Bus Pirate pin input path.
//   - Pin index constants for the captured pin vector.
//   - Field offsets inside a captured event word {timestamp, level}.
//   - Default sizes for the capture block.
//   - Helper to size the glitch-filter counter.
package bp_pin_pkg;

  // Bit positions of each pin inside the captured vector.
  localparam int AUX   = 0;
  localparam int MOSI  = 1;
  localparam int MISO  = 2;
  localparam int CLOCK = 3;

  // Default block sizes.
  localparam int DEF_WIDTH       = 2;
  localparam int DEF_FILT_CYCLES = 3;
  localparam int DEF_TS_W        = 16;
  localparam int DEF_DEPTH       = 8;

  // Event word layout: level vector in the low bits, timestamp above it.
  localparam int EVT_LVL_LSB = 0;
  localparam int EVT_TS_LSB  = DEF_WIDTH;

  // Timestamp LSB for a non-default pin count.
  function automatic int evt_ts_lsb(input int width);
    return width;
  endfunction

  // Filter counter must hold FILT_CYCLES-1 with a spare bit of headroom.
  function automatic int filt_cnt_w(input int filt_cycles);
    return $clog2(filt_cycles) + 1;
  endfunction

endpackage

// File: rtl/pin_filter.sv
// Single-pin input conditioning: two-flop synchroniser, persistence filter
// and registered edge pulses.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   din          : raw asynchronous pin value
//   level        : filtered level
//   rise, fall   : one-cycle pulses, the cycle after level goes 0->1 / 1->0
//   accept       : high in the cycle whose closing edge updates level
//   level_nxt    : value level takes at the next edge
module pin_filter
  import bp_pin_pkg::*;
#(
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept,
  output logic level_nxt
);

  localparam int CNT_W = filt_cnt_w(FILT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // A differing synced value is taken once it has been seen FILT_CYCLES times.
  assign accept    = (s2 != level) && (cnt == CNT_MAX);
  assign level_nxt = accept ? s2 : level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      // Any return to the current level restarts the persistence count.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Pulses compare level against its one-cycle-old copy.
      level_q <= level;
      rise    <= level & ~level_q;
      fall    <= ~level & level_q;
    end
  end

endmodule

// File: rtl/pin_capture.sv
// Pin capture: conditions the SB_IO D_IN_0 pin values and logs every filtered
// level change with a timestamp into a first-word-fall-through FIFO.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : runs the timestamp and allows event logging
//   din           : raw pin values (bit 0 AUX, bit 1 MOSI)
//   level         : filtered pin levels
//   rise, fall    : per-bit one-cycle edge pulses (independent of enable)
//   evt_valid     : FIFO holds at least one event
//   evt_ready     : consumer takes the head event
//   evt_data      : head event {timestamp, level}, zero while empty
//   overflow      : sticky, an event was dropped because the FIFO was full
//   clr_overflow  : clears overflow (a simultaneous drop keeps it set)
// Handshake: an event transfers on every clock edge where evt_valid and
// evt_ready are both high; evt_valid/evt_data do not depend on evt_ready.
module pin_capture
  import bp_pin_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES,
  parameter int TS_W        = DEF_TS_W,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      level,
  output logic [WIDTH-1:0]      rise,
  output logic [WIDTH-1:0]      fall,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [TS_W+WIDTH-1:0] evt_data,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int EW     = TS_W + WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int TS_LSB = evt_ts_lsb(WIDTH);

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] level_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    pin_filter #(
      .FILT_CYCLES (FILT_CYCLES)
    ) u_pin_filter (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din[i]),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .accept    (accept[i]),
      .level_nxt (level_nxt[i])
    );
  end

  // Timestamp: free-running while enabled, parked at zero otherwise.
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (enable) begin
      ts <= ts + TS_W'(1);
    end else begin
      ts <= '0;
    end
  end

  // Event FIFO.
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push_req;
  logic          pop;
  logic          do_push;
  logic          drop;
  logic [EW-1:0] entry;

  always_comb begin
    entry                          = '0;
    entry[TS_LSB +: TS_W]          = ts;
    entry[EVT_LVL_LSB +: WIDTH]    = level_nxt;
  end

  assign full      = (count == (AW+1)'(DEPTH));
  assign evt_valid = (count != '0);
  assign push_req  = enable & (|accept);
  assign pop       = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pin_capture.sv
module tb_pin_capture;
  import bp_pin_pkg::*;

  localparam int WIDTH  = 2;
  localparam int TS_W   = 16;
  localparam int TS_W_S = 4;
  localparam int EW     = TS_W + WIDTH;
  localparam int EW_S   = TS_W_S + WIDTH;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             evt_ready = 1'b0;
  logic             clr_overflow = 1'b0;
  logic [WIDTH-1:0] din = '0;

  logic [WIDTH-1:0] level, rise, fall;
  logic             evt_valid, overflow;
  logic [EW-1:0]    evt_data;

  logic [WIDTH-1:0] level_s, rise_s, fall_s;
  logic             evt_valid_s, overflow_s;
  logic [EW_S-1:0]  evt_data_s;

  always #5 clk = ~clk;

  pin_capture #(.WIDTH(WIDTH), .FILT_CYCLES(3), .TS_W(TS_W), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din(din),
    .level(level), .rise(rise), .fall(fall),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  // Narrow-timestamp copy sharing all inputs, used for the wrap check.
  pin_capture #(.WIDTH(WIDTH), .FILT_CYCLES(3), .TS_W(TS_W_S), .DEPTH(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din(din),
    .level(level_s), .rise(rise_s), .fall(fall_s),
    .evt_valid(evt_valid_s), .evt_ready(evt_ready), .evt_data(evt_data_s),
    .overflow(overflow_s), .clr_overflow(clr_overflow)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_cyc = 0;
  int rise_cnt[WIDTH];
  int fall_cnt[WIDTH];
  bit track_s = 1'b0;
  logic [EW-1:0]   exp_q[$];
  logic [EW_S-1:0] exp_s_q[$];
  int popped_ts[$];

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < WIDTH; i++) begin
        rise_cnt[i] += int'(rise[i]);
        fall_cnt[i] += int'(fall[i]);
      end
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < WIDTH; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected event for a din change driven in the cycle numbered c: it is
  // captured at edge c+1 and logged at edge c+5, carrying the timestamp
  // accumulated since enable was raised in cycle en_cyc.
  task automatic push_exp(input int c, input logic [WIDTH-1:0] lv);
    exp_q.push_back({TS_W'(c - en_cyc + 4), lv});
    if (track_s) exp_s_q.push_back({TS_W_S'(c - en_cyc + 4), lv});
  endtask

  // Drive a change that is expected to be logged, then let it settle.
  task automatic change(input logic [WIDTH-1:0] v, input bit logged);
    din = v;
    if (logged) push_exp(cyc, v);
    tick(5);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    evt_ready = 1'b0;
    while (exp_q.size() > 0 && guard < 60) begin
      if (evt_valid) begin
        check({tag, "_data"}, 32'(evt_data), 32'(exp_q.pop_front()));
        popped_ts.push_back(int'(evt_data[WIDTH +: TS_W]));
        if (exp_s_q.size() > 0) begin
          check({tag, "_data_s"}, 32'(evt_data_s), 32'(exp_s_q.pop_front()));
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
      end else begin
        tick();
      end
      guard++;
    end
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_empty"}, 32'(evt_valid), 32'd0);
    exp_q.delete();
    exp_s_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [WIDTH-1:0] v;
    clear_counts();

    // Reset with pins high: everything must read zero.
    din = 2'b11;
    tick(3);
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_pulses", 32'({rise, fall}), 32'd0);
    check("rst_small", 32'({level_s, rise_s, fall_s, overflow_s, evt_valid_s}), 32'd0);

    // Release: level follows five edges after the first capture.
    rst_n = 1'b1;
    enable = 1'b1;
    en_cyc = cyc;
    push_exp(cyc, 2'b11);
    clear_counts();
    tick(4);
    check("lat_early", 32'(level), 32'd0);
    tick();
    check("lat_level", 32'(level), 32'b11);
    tick(3);
    check("rise_aux", 32'(rise_cnt[AUX]), 32'd1);
    check("rise_mosi", 32'(rise_cnt[MOSI]), 32'd1);
    drain("reset_evt");

    // Both pins low, then a two-cycle glitch on MOSI.
    change(2'b00, 1'b1);
    check("low_level", 32'(level), 32'd0);
    drain("low_evt");
    clear_counts();
    din[MOSI] = 1'b1;
    tick(2);
    din[MOSI] = 1'b0;
    tick(8);
    check("glitch_level", 32'(level), 32'd0);
    check("glitch_rise", 32'(rise_cnt[MOSI]), 32'd0);
    check("glitch_valid", 32'(evt_valid), 32'd0);

    // Three-cycle pulse on MOSI is accepted at E0+4, then released.
    din = 2'b10;
    push_exp(cyc, 2'b10);
    tick(3);
    din = 2'b00;
    push_exp(cyc, 2'b00);
    tick();
    check("pulse_early", 32'(level), 32'd0);
    tick();
    check("pulse_level", 32'(level), 32'b10);
    tick(5);
    check("pulse_back", 32'(level), 32'd0);
    check("pulse_rise", 32'(rise_cnt[MOSI]), 32'd1);
    check("pulse_fall", 32'(fall_cnt[MOSI]), 32'd1);
    drain("pulse_evt");

    // Two AUX toggles 20 cycles apart after re-enabling.
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    en_cyc = cyc;
    tick(10);
    din = 2'b01;
    push_exp(cyc, 2'b01);
    tick(20);
    din = 2'b00;
    push_exp(cyc, 2'b00);
    tick(8);
    popped_ts.delete();
    drain("ts_evt");
    if (popped_ts.size() == 2) begin
      check("ts_delta", 32'(popped_ts[1] - popped_ts[0]), 32'd20);
    end else begin
      check("ts_count", 32'(popped_ts.size()), 32'd2);
    end

    // Nine accepted changes into an eight-entry FIFO.
    v = 2'b00;
    for (int k = 0; k < 9; k++) begin
      v[AUX] = ~v[AUX];
      change(v, k < 8);
      if (k == 7) check("ovf_at_full", 32'(overflow), 32'd0);
    end
    check("ovf_set", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    check("ovf_head", 32'(evt_data), 32'(exp_q[0]));

    // Full FIFO: pop coincides with the next push edge.
    v[AUX] = ~v[AUX];
    din = v;
    tick(4);
    evt_ready = 1'b1;
    check("full_head", 32'(evt_data), 32'(exp_q.pop_front()));
    push_exp(cyc - 4, v);
    tick();
    evt_ready = 1'b0;
    check("full_ovf", 32'(overflow), 32'd0);
    check("full_level", 32'(level), 32'(v));
    drain("full_evt");

    // Reset in the middle of operation drops pending events.
    v[AUX] = ~v[AUX];
    change(v, 1'b1);
    check("mid_valid_pre", 32'(evt_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(evt_valid), 32'd0);
    check("mid_level", 32'(level), 32'd0);
    exp_q.delete();
    din = 2'b00;
    enable = 1'b0;
    tick(3);
    rst_n = 1'b1;
    enable = 1'b1;
    en_cyc = cyc;
    track_s = 1'b1;

    // Timestamp wrap on the 4-bit copy: 18 mod 16 = 2.
    tick(14);
    din = 2'b01;
    push_exp(cyc, 2'b01);
    tick(6);
    drain("wrap_evt");

    // Disabled: level and pulses still work, nothing is logged.
    enable = 1'b0;
    clear_counts();
    change(2'b00, 1'b0);
    tick();
    check("dis_level", 32'(level), 32'd0);
    check("dis_fall", 32'(fall_cnt[AUX]), 32'd1);
    check("dis_valid", 32'(evt_valid), 32'd0);

    // Re-enabled timestamp restarts from zero.
    enable = 1'b1;
    en_cyc = cyc;
    tick(3);
    din = 2'b01;
    push_exp(cyc, 2'b01);
    tick(6);
    drain("reen_evt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
